// File: rtl/fe_stage_gshare_if.sv
// Fetch-stage bus: instruction memory port, DE stall, AGEX redirect,
// AGEX training port and the FE latch toward decode.
// master = fetch stage, slave = surrounding pipeline / memory.
interface fe_stage_gshare_if #(
  parameter int DBITS    = 32,
  parameter int INSTBITS = 32
);
  localparam int LATCH_W = 1 + INSTBITS + 4 * DBITS + 8;

  // Instruction memory (combinational read)
  logic [DBITS-1:0]    imem_addr;
  logic [INSTBITS-1:0] imem_rdata;

  // Decode back-pressure
  logic                stall_DE;

  // AGEX redirect
  logic                redirect_valid;
  logic [DBITS-1:0]    redirect_pc;

  // AGEX resolution / predictor training
  logic                upd_valid;
  logic                upd_is_br;
  logic                upd_taken;
  logic [DBITS-1:0]    upd_pc;
  logic [DBITS-1:0]    upd_target;
  logic [7:0]          upd_pht_index;

  // FE latch toward decode
  logic [LATCH_W-1:0]  FE_latch_out;

  modport master (
    output imem_addr, FE_latch_out,
    input  imem_rdata, stall_DE, redirect_valid, redirect_pc,
    input  upd_valid, upd_is_br, upd_taken, upd_pc, upd_target, upd_pht_index
  );

  modport slave (
    input  imem_addr, FE_latch_out,
    output imem_rdata, stall_DE, redirect_valid, redirect_pc,
    output upd_valid, upd_is_br, upd_taken, upd_pc, upd_target, upd_pht_index
  );
endinterface

// File: rtl/fe_stage_gshare.sv
// Fetch stage with gshare direction predictor (8-bit global history,
// 256 x 2-bit PHT) and a 16-entry direct-mapped BTB. Writes the FE latch
// consumed by decode; redirect beats stall beats advance. Training from
// AGEX is independent of stall/redirect and is visible to prediction
// from the cycle after the update.
module fe_stage_gshare #(
  parameter int               DBITS    = 32,
  parameter int               INSTBITS = 32,
  parameter logic [DBITS-1:0] START_PC = '0
) (
  input logic               clk,
  input logic               reset,
  fe_stage_gshare_if.master bus
);

  localparam int HIST_W    = 8;
  localparam int PHT_DEPTH = 1 << HIST_W;
  localparam int BTB_IDX_W = 4;
  localparam int BTB_DEPTH = 1 << BTB_IDX_W;
  localparam int TAG_W     = DBITS - 6;

  // FE latch layout, MSB first, as seen by decode.
  typedef struct packed {
    logic                valid;
    logic [INSTBITS-1:0] inst;
    logic [DBITS-1:0]    pc;
    logic [DBITS-1:0]    pcplus;
    logic [DBITS-1:0]    inst_count;
    logic [HIST_W-1:0]   pht_index;
    logic [DBITS-1:0]    predicted_next_pc;
  } fe_latch_t;

  // Architectural state
  logic [DBITS-1:0]  pc;
  logic [DBITS-1:0]  inst_count;
  logic [HIST_W-1:0] bhr;
  fe_latch_t         fe_latch;

  // Predictor storage
  logic [1:0]        pht        [PHT_DEPTH];
  logic              btb_valid  [BTB_DEPTH];
  logic [TAG_W-1:0]  btb_tag    [BTB_DEPTH];
  logic [DBITS-1:0]  btb_target [BTB_DEPTH];

  // Prediction on the current PC
  logic [DBITS-1:0]     pc_plus4;
  logic [HIST_W-1:0]    pht_index;
  logic [BTB_IDX_W-1:0] btb_idx;
  logic                 btb_hit;
  logic                 pred_taken;
  logic [DBITS-1:0]     predicted_next_pc;

  // Training-port decode
  logic [BTB_IDX_W-1:0] upd_btb_idx;
  logic [1:0]           upd_ctr;
  logic                 train_br;
  logic                 train_btb;
  logic                 upd_pc_unused;

  assign bus.imem_addr    = pc;
  assign bus.FE_latch_out = fe_latch;

  // Instructions are word aligned; the low PC bits of a resolved branch
  // carry no information for the BTB.
  assign upd_pc_unused = ^bus.upd_pc[1:0];

  // Combinational next-PC prediction from pre-update predictor state.
  always_comb begin
    // NOTE: every signal gets a value on every path through this block, so
    // no storage (latch) can be inferred from a missing assignment.
    pc_plus4          = pc + DBITS'(4);
    pht_index         = pc[9:2] ^ bhr;
    btb_idx           = pc[5:2];
    btb_hit           = btb_valid[btb_idx] && (btb_tag[btb_idx] == pc[DBITS-1:6]);
    pred_taken        = btb_hit && pht[pht_index][1];
    predicted_next_pc = pred_taken ? btb_target[btb_idx] : pc_plus4;
  end

  // Decode the training request once so the storage blocks stay simple.
  always_comb begin
    upd_btb_idx = bus.upd_pc[5:2];
    upd_ctr     = pht[bus.upd_pht_index];
    train_br    = bus.upd_valid && bus.upd_is_br;
    train_btb   = bus.upd_valid && bus.upd_taken;
  end

  // PC, instruction counter and FE latch: redirect > stall > advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      pc         <= START_PC;
      inst_count <= '0;
      fe_latch   <= '0;
    end else if (bus.redirect_valid) begin
      pc       <= bus.redirect_pc;
      fe_latch <= '0;
    end else if (!bus.stall_DE) begin
      pc         <= predicted_next_pc;
      inst_count <= inst_count + DBITS'(1);
      fe_latch   <= '{
        valid:             1'b1,
        inst:              bus.imem_rdata,
        pc:                pc,
        pcplus:            pc_plus4,
        inst_count:        inst_count,
        pht_index:         pht_index,
        predicted_next_pc: predicted_next_pc
      };
    end
  end

  // Global history shifts in the outcome of every resolved conditional branch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bhr <= '0;
    end else if (train_br) begin
      bhr <= {bhr[HIST_W-2:0], bus.upd_taken};
    end
  end

  // PHT 2-bit saturating counters, trained by conditional branches only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the PHT must come out of reset weakly not-taken, so every entry
      // is reset here; BTB tag/target are left unreset because valid gates them.
      for (int i = 0; i < PHT_DEPTH; i++) begin
        pht[i] <= 2'b01;
      end
    end else if (train_br) begin
      if (bus.upd_taken) begin
        if (upd_ctr != 2'b11) pht[bus.upd_pht_index] <= upd_ctr + 2'b01;
      end else begin
        if (upd_ctr != 2'b00) pht[bus.upd_pht_index] <= upd_ctr - 2'b01;
      end
    end
  end

  // BTB valid bits: any taken control transfer allocates its entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_valid[i] <= 1'b0;
      end
    end else if (train_btb) begin
      btb_valid[upd_btb_idx] <= 1'b1;
    end
  end

  // BTB tag/target payload, overwriting whatever entry was resident.
  always_ff @(posedge clk) begin
    if (train_btb) begin
      btb_tag[upd_btb_idx]    <= bus.upd_pc[DBITS-1:6];
      btb_target[upd_btb_idx] <= bus.upd_target;
    end
  end

endmodule

// File: tb/tb_fe_stage_gshare.sv
// Directed bench for fe_stage_gshare: sequential fetch, stall, redirect,
// gshare training, counter saturation, JAL/BTB conflict and mid-run reset.
module tb_fe_stage_gshare;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [31:0] exp_cnt;

  fe_stage_gshare_if #(.DBITS(32), .INSTBITS(32)) bus ();

  fe_stage_gshare #(.DBITS(32), .INSTBITS(32), .START_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction memory model: instruction word is derived from its address.
  assign bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [168:0] exp_latch(input logic [31:0] pc,
                                             input logic [31:0] cnt,
                                             input logic [7:0]  idx,
                                             input logic [31:0] pred);
    return {1'b1, pc ^ 32'hA5A5_0000, pc, pc + 32'd4, cnt, idx, pred};
  endfunction

  task automatic check(input string tag, input logic [168:0] got, input logic [168:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic update(input logic is_br, input logic taken, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic [7:0] idx);
    bus.upd_valid     = 1'b1;
    bus.upd_is_br     = is_br;
    bus.upd_taken     = taken;
    bus.upd_pc        = pc;
    bus.upd_target    = tgt;
    bus.upd_pht_index = idx;
    step();
    bus.upd_valid     = 1'b0;
  endtask

  // Redirect (under stall) to pc, then fetch it once and check the latch.
  task automatic fetch_at(input string tag, input logic [31:0] pc,
                          input logic [7:0] idx, input logic [31:0] pred);
    bus.stall_DE       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    step();
    check({tag, "_bubble"}, bus.FE_latch_out, '0);
    bus.redirect_valid = 1'b0;
    bus.stall_DE       = 1'b0;
    step();
    check(tag, bus.FE_latch_out, exp_latch(pc, exp_cnt, idx, pred));
    check({tag, "_nextpc"}, 169'(bus.imem_addr), 169'(pred));
    exp_cnt++;
    bus.stall_DE = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = 0;
    reset    = 1'b1;
    bus.stall_DE       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.upd_valid      = 1'b0;
    bus.upd_is_br      = 1'b0;
    bus.upd_taken      = 1'b0;
    bus.upd_pc         = '0;
    bus.upd_target     = '0;
    bus.upd_pht_index  = '0;

    // Reset state
    step();
    step();
    check("reset_latch", bus.FE_latch_out, '0);
    check("reset_addr", 169'(bus.imem_addr), 169'(32'h0));
    @(negedge clk);
    reset = 1'b0;

    // Sequential fetch 0x0, 0x4, 0x8
    for (int i = 0; i < 3; i++) begin
      logic [31:0] p;
      p = 32'(i * 4);
      step();
      check("seq_fetch", bus.FE_latch_out, exp_latch(p, exp_cnt, p[9:2], p + 32'd4));
      exp_cnt++;
    end

    // Stall hold for three edges
    bus.stall_DE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", bus.FE_latch_out, exp_latch(32'h8, 32'd2, 8'h02, 32'hC));
    end
    check("stall_addr", 169'(bus.imem_addr), 169'(32'hC));
    bus.stall_DE = 1'b0;
    step();
    check("after_stall", bus.FE_latch_out, exp_latch(32'hC, 32'd3, 8'h03, 32'h10));
    exp_cnt++;

    // Redirect together with stall: redirect wins, bubble does not count
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    bus.stall_DE       = 1'b1;
    step();
    check("redir_bubble", bus.FE_latch_out, '0);
    check("redir_addr", 169'(bus.imem_addr), 169'(32'h100));
    bus.redirect_valid = 1'b0;
    bus.stall_DE       = 1'b0;
    step();
    check("redir_target", bus.FE_latch_out, exp_latch(32'h100, 32'd4, 8'h40, 32'h104));
    exp_cnt++;
    bus.stall_DE = 1'b1;

    // Gshare training: two taken updates -> BHR=0b11, PHT[7]=11, BTB[4]=0x10->0x40
    update(1'b1, 1'b1, 32'h10, 32'h40, 8'h07);
    update(1'b1, 1'b1, 32'h10, 32'h40, 8'h07);
    fetch_at("gshare_hit", 32'h10, 8'h07, 32'h40);
    bus.stall_DE = 1'b0;
    step();
    check("gshare_follow", bus.FE_latch_out, exp_latch(32'h40, exp_cnt, 8'h13, 32'h44));
    exp_cnt++;
    bus.stall_DE = 1'b1;

    // Saturation high: two more taken (stays 11), one not-taken -> 10, BHR=0x1E
    update(1'b1, 1'b1, 32'h10, 32'h40, 8'h07);
    update(1'b1, 1'b1, 32'h10, 32'h40, 8'h07);
    update(1'b1, 1'b0, 32'h10, 32'h40, 8'h07);
    update(1'b0, 1'b1, 32'h64, 32'h200, 8'h00);   // JAL: BTB[9] probe entry only
    fetch_at("bhr_1e", 32'h10, 8'h1A, 32'h14);
    fetch_at("sat_hi", 32'h64, 8'h07, 32'h200);

    // Saturation low: 10 -> 01 -> 00 -> 00, BHR=0xF0
    update(1'b1, 1'b0, 32'h10, 32'h40, 8'h07);
    update(1'b1, 1'b0, 32'h10, 32'h40, 8'h07);
    update(1'b1, 1'b0, 32'h10, 32'h40, 8'h07);
    update(1'b0, 1'b1, 32'h3DC, 32'h300, 8'h00);  // JAL: BTB[7] probe entry only
    fetch_at("sat_lo", 32'h3DC, 8'h07, 32'h3E0);

    // JAL overwrites BTB[4]; BHR and PHT untouched
    update(1'b0, 1'b1, 32'h50, 32'h80, 8'h00);
    fetch_at("btb_conflict", 32'h10, 8'hF4, 32'h14);

    // Fetch 0x50 in the same cycle as a taken update: pre-update prediction
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h50;
    step();
    check("same_cyc_bubble", bus.FE_latch_out, '0);
    bus.redirect_valid = 1'b0;
    bus.stall_DE       = 1'b0;
    update(1'b1, 1'b1, 32'h50, 32'h80, 8'hF5);
    check("same_cyc_pred", bus.FE_latch_out, exp_latch(32'h50, exp_cnt, 8'hE4, 32'h54));
    exp_cnt++;
    bus.stall_DE = 1'b1;
    fetch_at("jal_taken", 32'h50, 8'hF5, 32'h80);
    bus.stall_DE = 1'b0;
    step();
    check("jal_follow", bus.FE_latch_out, exp_latch(32'h80, exp_cnt, 8'hC1, 32'h84));
    exp_cnt++;

    // Reset mid-operation with redirect and update pending
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h500;
    bus.upd_valid      = 1'b1;
    bus.upd_is_br      = 1'b1;
    bus.upd_taken      = 1'b1;
    bus.upd_pht_index  = 8'h33;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_latch", bus.FE_latch_out, '0);
    check("midrst_addr", 169'(bus.imem_addr), 169'(32'h0));
    bus.redirect_valid = 1'b0;
    bus.upd_valid      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b0;
    exp_cnt = 0;
    step();
    check("postrst_fetch", bus.FE_latch_out, exp_latch(32'h0, 32'd0, 8'h00, 32'h4));
    exp_cnt++;
    fetch_at("postrst_bhr", 32'h10, 8'h04, 32'h14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fe_stage_gshare.md
# fe_stage_gshare

Fetch stage feeding the decode stage. Holds the PC, reads instruction memory, predicts the next PC with a gshare direction predictor (8-bit global history, 256×2-bit PHT) plus a 16-entry direct-mapped BTB, and writes the FE latch. It honours the DE stall, takes redirects from AGEX, and trains the predictor from AGEX resolution.

## Interface
- `START_PC`, default 32'h0: PC loaded at reset.
- `DBITS`, default 32: data/PC width.
- `INSTBITS`, default 32: instruction width.
- `clk` in 1: clock; all state changes on posedge.
- `reset` in 1: asynchronous, active-high.
- `imem_addr` out DBITS: equals PC; word address is `PC[DBITS-1:2]`.
- `imem_rdata` in INSTBITS: instruction at `imem_addr`, combinational, same cycle.
- `stall_DE` in 1: DE stall (`from_DE_to_FE`).
- `redirect_valid` in 1: AGEX mispredict or flush.
- `redirect_pc` in DBITS: correct next PC.
- `upd_valid` in 1: resolved control-flow instruction.
- `upd_is_br` in 1: 1 for a conditional branch, 0 for JAL/JALR.
- `upd_taken` in 1: resolved direction.
- `upd_pc` in DBITS: PC of the resolved instruction.
- `upd_target` in DBITS: resolved taken target.
- `upd_pht_index` in 8: PHT index carried with the instruction.
- `FE_latch_out` out 169: fields MSB→LSB are valid(1), inst(32), PC(32), pcplus(32), inst_count(32), pht_index(8), predicted_next_pc(32).

## Operation
- **State:**
  - PC register.
  - `inst_count` (DBITS).
  - BHR (8 bits).
  - PHT: 256 × 2-bit saturating counters.
  - BTB: 16 entries of {valid, tag = `PC[31:6]`, target}, indexed by `PC[5:2]`.
  - FE latch.
- **Prediction, combinational on the current PC:**
  - `pht_index = PC[9:2] ^ BHR`.
  - `btb_hit = BTB[PC[5:2]].valid && tag == PC[31:6]`.
  - `pred_taken = btb_hit && PHT[pht_index][1]`.
  - `predicted_next_pc = pred_taken ? BTB target : PC+4`.
  - `pcplus = PC+4`, with wrap-around mod 2^32.
- **Per-cycle priority:** redirect > stall > advance.
  - Redirect: PC ← `redirect_pc`; latch ← all zeros (bubble); `inst_count` holds.
  - Stall (no redirect): PC, latch and `inst_count` all hold.
  - Advance: latch ← {1, `imem_rdata`, PC, PC+4, `inst_count`, `pht_index`, `predicted_next_pc`}; PC ← `predicted_next_pc`; `inst_count` ← `inst_count`+1.
- **Training on `upd_valid`, independent of stall/redirect:**
  - If `upd_is_br`:
    - `PHT[upd_pht_index]` is incremented when taken (saturating at 11) and decremented when not taken (saturating at 00).
    - BHR ← {BHR[6:0], `upd_taken`}.
  - If `upd_taken`: `BTB[upd_pc[5:2]]` ← {1, `upd_pc[31:6]`, `upd_target`}, overwriting any resident entry.
  - If `upd_is_br=0` (JAL/JALR): PHT and BHR are untouched.
- **Same-cycle read/update:** prediction in an update cycle uses the pre-update PHT/BHR/BTB values. The new values are visible from the next cycle.
- **Reset (asynchronous):**
  - PC = `START_PC`; `inst_count` = 0; BHR = 0.
  - All PHT counters = 01 (weakly not-taken).
  - All BTB valid = 0.
  - `FE_latch_out` = 0.
  - `imem_addr` = `START_PC`.
- **Reset mid-operation:** clears all of the above immediately, regardless of pending redirect, stall or update.

## Timing
- Fetch latency is one cycle: an instruction at PC appears in the latch on the first non-stalled posedge.
- **Redirect:**
  - Redirect asserted in cycle N → bubble in the latch after edge N, and PC = `redirect_pc`.
  - The target instruction is latched at edge N+1 if not stalled.
- **Stall:** stall is level-sensitive. The latch holds unchanged for every cycle `stall_DE`=1.
- **Redirect together with stall:** redirect wins; the latch gets the bubble.
- **Training:** BTB/PHT/BHR writes take effect at the posedge of the `upd_valid` cycle. They first influence prediction one cycle later.
- No handshake beyond stall; `upd_*` is sampled only when `upd_valid`=1.

## Test plan
- **Reset and sequential fetch.** Assert reset, release, no stall, imem returns `PC^32'hA5A5_0000`. Required:
  - Latch PCs 0x0, 0x4, 0x8 on successive edges, with pcplus = PC+4.
  - `inst_count` 0, 1, 2; `pht_index` = PC[9:2].
  - `predicted_next_pc` = PC+4.
- **Stall hold.** Stall for 3 cycles after PC 0x8 is latched. Required: latch unchanged for 3 edges; next latched PC is 0xC with `inst_count` 3.
- **Redirect priority.** Assert `redirect_valid` with `redirect_pc`=0x100 and `stall_DE`=1 in the same cycle. Required:
  - Latch becomes all zeros.
  - Next edge latches PC 0x100 with valid=1.
  - `inst_count` is not incremented for the bubble.
- **Gshare training.**
  - Stimulus: two updates with `upd_valid`=1, `upd_is_br`=1, `upd_taken`=1, `upd_pc`=0x10, `upd_target`=0x40, `upd_pht_index`=0x07.
  - Required state after training: BHR=0b11; PHT[0x07]=11.
  - Required fetch result: fetching 0x10 gives `pht_index`=0x07, `predicted_next_pc`=0x40, and the next latched PC is 0x40.
- **Saturation and not-taken.**
  - Two more taken updates to index 0x07 leave the counter at 11.
  - Then three not-taken updates take the counter 11→10→01→00, and a fourth keeps it at 00.
  - Each update shifts the BHR; with BHR then = 0x1E, a fetch at 0x10 uses index 0x04^0x1E = 0x1A.
- **JAL update plus BTB conflict.**
  - `upd_is_br`=0, taken, pc=0x50 → target 0x80. Required: BHR/PHT unchanged; BTB[4] overwrites the 0x10 entry.
  - Fetching 0x10 now misses and predicts 0x14.
  - Fetching 0x50 predicts 0x80 only if `PHT[0x14^BHR][1]`=1; otherwise it predicts 0x54.
